// File: rtl/grain_pkg.sv
// Shared definitions for the grain keystream generator and its consumers.
package grain_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        WAIT_PT = 3'd2,
        SHIFT   = 3'd3,
        OUT     = 3'd4
    } grain_state_e;

    localparam int GRAIN_DATA_W = 8;
    localparam int GRAIN_SEED_W = 105;

    // Bit counter must reach both a full byte and the whole warm-up run.
    function automatic int ks_cnt_w(input int data_w, input int warmup_bits);
        int max_bits;
        max_bits = (warmup_bits > data_w) ? warmup_bits : data_w;
        return $clog2(max_bits + 1);
    endfunction

endpackage

// File: rtl/grain_ks_deser.sv
// MSB-first keystream deserialiser with a bit counter; done marks DATA_W shifts.
module grain_ks_deser
    import grain_pkg::*;
#(
    parameter int DATA_W = GRAIN_DATA_W,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic              bit_in,
    output logic [DATA_W-1:0] word,
    output logic [CW-1:0]     count,
    output logic              done
);

    always_ff @(posedge clk) begin
        if (rst) begin
            word  <= '0;
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (shift) begin
            word <= {word[DATA_W-2:0], bit_in};
            if (count != '1) begin
                count <= count + 1'b1;
            end
        end
    end

    assign done = (count == CW'(DATA_W));

endmodule

// File: rtl/grain_ks_xor.sv
// Grain keystream consumer: optional warm-up discard, then byte-wise XOR of pt into ct.
// Build option GRAIN_KS_TAP_EN adds the ks_word output (keystream byte behind ct_data).
module grain_ks_xor
    import grain_pkg::*;
#(
    parameter int DATA_W      = GRAIN_DATA_W,
    parameter int WARMUP_BITS = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              ks_bit,
    output logic              ks_shift,
    input  logic [DATA_W-1:0] pt_data,
    input  logic              pt_valid,
    output logic              pt_ready,
    output logic [DATA_W-1:0] ct_data,
    output logic              ct_valid,
    input  logic              ct_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  byte_count
`ifdef GRAIN_KS_TAP_EN
    ,
    output logic [DATA_W-1:0] ks_word
`endif
);

    localparam int KS_CNT_W = ks_cnt_w(DATA_W, WARMUP_BITS);
    localparam logic [KS_CNT_W-1:0] WARM_LAST =
        KS_CNT_W'((WARMUP_BITS > 0) ? WARMUP_BITS - 1 : 0);

    grain_state_e         state;
    grain_state_e         next_state;
    logic [DATA_W-1:0]    pt_q;
    logic [DATA_W-1:0]    deser_word;
    logic [KS_CNT_W-1:0]  deser_count;
    logic                 deser_done;
    logic                 deser_clr;
    logic                 ct_load;
    logic                 bc_inc;
    logic                 session_start;

    grain_ks_deser #(
        .DATA_W (DATA_W),
        .CW     (KS_CNT_W)
    ) u_deser (
        .clk    (clk),
        .rst    (rst),
        .clr    (deser_clr),
        .shift  (ks_shift),
        .bit_in (ks_bit),
        .word   (deser_word),
        .count  (deser_count),
        .done   (deser_done)
    );

    // Both byte ports: a transfer happens on a rising edge where valid and
    // ready are both high; ct_valid/ct_data hold steady until that edge.
    always_comb begin
        next_state    = state;
        deser_clr     = 1'b0;
        ct_load       = 1'b0;
        bc_inc        = 1'b0;
        session_start = 1'b0;
        case (state)
            IDLE: begin
                deser_clr = 1'b1;
                if (start) begin
                    session_start = 1'b1;
                    next_state    = (WARMUP_BITS > 0) ? WARMUP : WAIT_PT;
                end
            end
            WARMUP: begin
                if (deser_count == WARM_LAST) begin
                    next_state = WAIT_PT;
                end
            end
            WAIT_PT: begin
                deser_clr = 1'b1;
                if (pt_valid) begin
                    next_state = SHIFT;
                end else if (stop) begin
                    next_state = IDLE;
                end
            end
            SHIFT: begin
                // ct is built from the settled word one edge after the last shift.
                if (deser_done) begin
                    ct_load    = 1'b1;
                    next_state = OUT;
                end
            end
            OUT: begin
                if (ct_ready) begin
                    bc_inc     = 1'b1;
                    next_state = WAIT_PT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pt_q       <= '0;
            ct_data    <= '0;
            byte_count <= '0;
        end else begin
            state <= next_state;
            if (state == WAIT_PT && pt_valid) begin
                pt_q <= pt_data;
            end
            if (ct_load) begin
                ct_data <= pt_q ^ deser_word;
            end
            if (session_start) begin
                byte_count <= '0;
            end else if (bc_inc && byte_count != '1) begin
                byte_count <= byte_count + 1'b1;
            end
        end
    end

`ifdef GRAIN_KS_TAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ks_word <= '0;
        end else if (ct_load) begin
            ks_word <= deser_word;
        end
    end
`endif

    // Decoded from registers only, so grain sees a clean shift enable.
    assign ks_shift = (state == WARMUP) || (state == SHIFT && !deser_done);
    assign pt_ready = (state == WAIT_PT);
    assign ct_valid = (state == OUT);
    assign busy     = (state != IDLE);

endmodule
